// File: rtl/pair_alu_arbiter.sv
// Two-channel FWFT operand-pair ALU with round-robin arbitration onto one result FIFO.
// A grant pops both operands of one channel; the registered result is written the following cycle.
module pair_alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CH0_OP     = 0,
    parameter int CH1_OP     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  c0_inA_rd_en,
    input  logic                  c0_inA_empty,
    input  logic [DATA_WIDTH-1:0] c0_inA_dout,
    output logic                  c0_inB_rd_en,
    input  logic                  c0_inB_empty,
    input  logic [DATA_WIDTH-1:0] c0_inB_dout,
    output logic                  c1_inA_rd_en,
    input  logic                  c1_inA_empty,
    input  logic [DATA_WIDTH-1:0] c1_inA_dout,
    output logic                  c1_inB_rd_en,
    input  logic                  c1_inB_empty,
    input  logic [DATA_WIDTH-1:0] c1_inB_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_tag,
    output logic [15:0]           grant_count0,
    output logic [15:0]           grant_count1
);

    typedef enum logic {ARB = 1'b0, WRITE = 1'b1} state_t;

    state_t                     state_reg, state_next;
    logic                       last_grant_reg;
    logic                       tag_reg;
    logic [DATA_WIDTH-1:0]      result_reg;
    logic [1:0][DATA_WIDTH-1:0] op_a, op_b, alu;
    logic [1:0]                 empty_a, empty_b, eligible;
    logic                       grant_valid;
    logic                       grant_ch;
    logic                       write_now;

    assign op_a    = {c1_inA_dout, c0_inA_dout};
    assign op_b    = {c1_inB_dout, c0_inB_dout};
    assign empty_a = {c1_inA_empty, c0_inA_empty};
    assign empty_b = {c1_inB_empty, c0_inB_empty};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            localparam int OP = (gi == 0) ? CH0_OP : CH1_OP;
            logic [15:0] count_reg;

            assign eligible[gi] = ~empty_a[gi] & ~empty_b[gi];

            if (OP == 1) begin : g_sub
                assign alu[gi] = op_a[gi] - op_b[gi];
            end else begin : g_add
                assign alu[gi] = op_a[gi] + op_b[gi];
            end

            // Completed-write counter; sticks at all-ones instead of wrapping.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    count_reg <= '0;
                end else if (write_now && (tag_reg == 1'(gi)) && (count_reg != 16'hFFFF)) begin
                    count_reg <= count_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign grant_count0 = g_chan[0].count_reg;
    assign grant_count1 = g_chan[1].count_reg;

    // Grants are gated by reset so no FIFO word is popped while the block is held in reset.
    always_comb begin
        state_next  = state_reg;
        grant_valid = 1'b0;
        grant_ch    = 1'b0;
        write_now   = 1'b0;
        case (state_reg)
            ARB: begin
                if (reset && (eligible != 2'b00)) begin
                    grant_valid = 1'b1;
                    grant_ch    = (eligible == 2'b11) ? ~last_grant_reg : eligible[1];
                    state_next  = WRITE;
                end
            end
            WRITE: begin
                if (!out_full) begin
                    write_now  = 1'b1;
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ARB;
            last_grant_reg <= 1'b1;
            tag_reg        <= 1'b0;
            result_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_valid) begin
                result_reg     <= alu[grant_ch];
                tag_reg        <= grant_ch;
                last_grant_reg <= grant_ch;
            end
        end
    end

    assign c0_inA_rd_en = grant_valid & ~grant_ch;
    assign c0_inB_rd_en = grant_valid & ~grant_ch;
    assign c1_inA_rd_en = grant_valid & grant_ch;
    assign c1_inB_rd_en = grant_valid & grant_ch;
    assign out_wr_en    = write_now;
    assign out_din      = result_reg;
    assign out_tag      = tag_reg;

endmodule

// File: tb/tb_pair_alu_arbiter.sv
// Bench for pair_alu_arbiter: FWFT FIFO models feed the DUT, a per-channel scoreboard checks every write.
module tb_pair_alu_arbiter;

    localparam int DW     = 32;
    localparam int CH0_OP = 0;
    localparam int CH1_OP = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          c0_inA_rd_en, c0_inB_rd_en, c1_inA_rd_en, c1_inB_rd_en;
    logic          c0_inA_empty, c0_inB_empty, c1_inA_empty, c1_inB_empty;
    logic [DW-1:0] c0_inA_dout, c0_inB_dout, c1_inA_dout, c1_inB_dout;
    logic          out_wr_en;
    logic          out_full = 1'b0;
    logic [DW-1:0] out_din;
    logic          out_tag;
    logic [15:0]   grant_count0, grant_count1;

    logic [DW-1:0] q_c0a[$], q_c0b[$], q_c1a[$], q_c1b[$];
    logic [DW-1:0] exp_q0[$], exp_q1[$];
    int            tag_log[$];
    int            wr_cycle[$];
    int            checks = 0;
    int            errors = 0;
    int            cycle = 0;
    int            grants = 0;
    int            pops_c0a = 0, pops_c0b = 0, pops_c1a = 0, pops_c1b = 0;
    logic [DW-1:0] last_out0 = '0, last_out1 = '0;

    pair_alu_arbiter #(.DATA_WIDTH(DW), .CH0_OP(CH0_OP), .CH1_OP(CH1_OP)) dut (
        .clock(clock), .reset(reset),
        .c0_inA_rd_en(c0_inA_rd_en), .c0_inA_empty(c0_inA_empty), .c0_inA_dout(c0_inA_dout),
        .c0_inB_rd_en(c0_inB_rd_en), .c0_inB_empty(c0_inB_empty), .c0_inB_dout(c0_inB_dout),
        .c1_inA_rd_en(c1_inA_rd_en), .c1_inA_empty(c1_inA_empty), .c1_inA_dout(c1_inA_dout),
        .c1_inB_rd_en(c1_inB_rd_en), .c1_inB_empty(c1_inB_empty), .c1_inB_dout(c1_inB_dout),
        .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din), .out_tag(out_tag),
        .grant_count0(grant_count0), .grant_count1(grant_count1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    function automatic void refresh();
        c0_inA_empty = (q_c0a.size() == 0);
        c0_inB_empty = (q_c0b.size() == 0);
        c1_inA_empty = (q_c1a.size() == 0);
        c1_inB_empty = (q_c1b.size() == 0);
        c0_inA_dout  = (q_c0a.size() != 0) ? q_c0a[0] : '0;
        c0_inB_dout  = (q_c0b.size() != 0) ? q_c0b[0] : '0;
        c1_inA_dout  = (q_c1a.size() != 0) ? q_c1a[0] : '0;
        c1_inB_dout  = (q_c1b.size() != 0) ? q_c1b[0] : '0;
    endfunction

    // FIFO models and output monitor. Pops land 1 time unit after the consuming edge;
    // DUT outputs are sampled 3 units after the falling edge, once all inputs have settled.
    initial begin
        logic          p_c0a, p_c0b, p_c1a, p_c1b, prev_rd, any_rd, have_exp;
        logic [DW-1:0] dummy, expv;
        p_c0a = 1'b0; p_c0b = 1'b0; p_c1a = 1'b0; p_c1b = 1'b0; prev_rd = 1'b0;
        refresh();
        forever begin
            @(posedge clock);
            #1;
            if (p_c0a) begin
                if (q_c0a.size() == 0) begin errors++; $display("FAIL pop_c0a underflow"); end
                else begin dummy = q_c0a.pop_front(); pops_c0a++; end
            end
            if (p_c0b) begin
                if (q_c0b.size() == 0) begin errors++; $display("FAIL pop_c0b underflow"); end
                else begin dummy = q_c0b.pop_front(); pops_c0b++; end
            end
            if (p_c1a) begin
                if (q_c1a.size() == 0) begin errors++; $display("FAIL pop_c1a underflow"); end
                else begin dummy = q_c1a.pop_front(); pops_c1a++; end
            end
            if (p_c1b) begin
                if (q_c1b.size() == 0) begin errors++; $display("FAIL pop_c1b underflow"); end
                else begin dummy = q_c1b.pop_front(); pops_c1b++; end
            end
            refresh();
            @(negedge clock);
            #2;
            refresh();
            #1;
            p_c0a = c0_inA_rd_en; p_c0b = c0_inB_rd_en;
            p_c1a = c1_inA_rd_en; p_c1b = c1_inB_rd_en;
            any_rd = p_c0a | p_c0b | p_c1a | p_c1b;
            if (any_rd) begin
                checks++;
                if ((p_c0a !== p_c0b) || (p_c1a !== p_c1b) || (p_c0a && p_c1a) || prev_rd) begin
                    errors++;
                    $display("FAIL rd_en_protocol got c0=%b%b c1=%b%b prev=%b want paired, one channel, not back-to-back",
                             p_c0a, p_c0b, p_c1a, p_c1b, prev_rd);
                end
                grants++;
            end
            prev_rd = any_rd;
            if (out_wr_en === 1'b1) begin
                checks++;
                have_exp = 1'b1;
                expv = '0;
                if (out_tag === 1'b0 && exp_q0.size() != 0) expv = exp_q0.pop_front();
                else if (out_tag === 1'b1 && exp_q1.size() != 0) expv = exp_q1.pop_front();
                else begin
                    have_exp = 1'b0;
                    errors++;
                    $display("FAIL unexpected_write got tag=%b din=%h want no write", out_tag, out_din);
                end
                if (have_exp && out_din !== expv) begin
                    errors++;
                    $display("FAIL write_data got %h want %h (tag %b)", out_din, expv, out_tag);
                end
                if (out_tag === 1'b1) last_out1 = out_din; else last_out0 = out_din;
                tag_log.push_back(int'(out_tag));
                wr_cycle.push_back(cycle);
                $display("write cycle=%0d tag=%b din=%h", cycle, out_tag, out_din);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_pair(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        if (ch == 0) begin
            r = (CH0_OP == 1) ? a - b : a + b;
            q_c0a.push_back(a); q_c0b.push_back(b); exp_q0.push_back(r);
        end else begin
            r = (CH1_OP == 1) ? a - b : a + b;
            q_c1a.push_back(a); q_c1b.push_back(b); exp_q1.push_back(r);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((q_c0a.size() + q_c0b.size() + q_c1a.size() + q_c1b.size() +
                exp_q0.size() + exp_q1.size()) != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d want 0 within 300 cycles", name,
                     exp_q0.size() + exp_q1.size());
        end
        repeat (3) tick();
    endtask

    task automatic wait_grant(input string name);
        int g0 = grants;
        int n = 0;
        do begin
            tick();
            n++;
        end while (grants == g0 && n < 50);
        checks++;
        if (grants == g0) begin
            errors++;
            $display("FAIL %s_grant got none want a grant within 50 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        out_full = 1'b0;
        repeat (2) tick();
        checks++;
        if ({c0_inA_rd_en, c0_inB_rd_en, c1_inA_rd_en, c1_inB_rd_en} !== 4'b0) begin
            errors++; $display("FAIL reset_rd_en got %b%b%b%b want 0000",
                               c0_inA_rd_en, c0_inB_rd_en, c1_inA_rd_en, c1_inB_rd_en);
        end
        checks++;
        if (out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", out_wr_en); end
        checks++;
        if (out_din !== '0) begin errors++; $display("FAIL reset_din got %h want 0", out_din); end
        checks++;
        if (out_tag !== 1'b0) begin errors++; $display("FAIL reset_tag got %b want 0", out_tag); end
        checks++;
        if (grant_count0 !== 16'd0 || grant_count1 !== 16'd0) begin
            errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", grant_count0, grant_count1);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ch0_only();
        push_pair(0, 32'd5, 32'd3);
        wait_idle("ch0_only");
        checks++;
        if (last_out0 !== 32'd8) begin errors++; $display("FAIL ch0_only_din got %h want 8", last_out0); end
        checks++;
        if (pops_c0a != 1 || pops_c0b != 1 || pops_c1a != 0 || pops_c1b != 0) begin
            errors++; $display("FAIL ch0_only_pops got %0d/%0d/%0d/%0d want 1/1/0/0",
                               pops_c0a, pops_c0b, pops_c1a, pops_c1b);
        end
        checks++;
        if (grant_count0 !== 16'd1 || grant_count1 !== 16'd0) begin
            errors++; $display("FAIL ch0_only_counts got %0d/%0d want 1/0", grant_count0, grant_count1);
        end
    endtask

    task automatic test_ch1_only();
        push_pair(1, 32'd5, 32'd7);
        wait_idle("ch1_only");
        checks++;
        if (last_out1 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ch1_only_din got %h want fffffffe", last_out1); end
        checks++;
        if (tag_log.size() == 0 || tag_log[tag_log.size()-1] != 1) begin
            errors++; $display("FAIL ch1_only_tag got log size %0d want last tag 1", tag_log.size());
        end
        checks++;
        if (grant_count1 !== 16'd1) begin errors++; $display("FAIL ch1_only_count got %0d want 1", grant_count1); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b0 = grant_count0;
        logic [15:0] b1 = grant_count1;
        tag_log.delete();
        wr_cycle.delete();
        for (int i = 0; i < 4; i++) begin
            push_pair(0, DW'($urandom), DW'($urandom));
            push_pair(1, DW'($urandom), DW'($urandom));
        end
        wait_idle("back_to_back");
        checks++;
        if (tag_log.size() != 8) begin errors++; $display("FAIL b2b_writes got %0d want 8", tag_log.size()); end
        for (int i = 0; i < tag_log.size(); i++) begin
            checks++;
            if (tag_log[i] != (i % 2)) begin errors++; $display("FAIL b2b_tag[%0d] got %0d want %0d", i, tag_log[i], i % 2); end
        end
        for (int i = 1; i < wr_cycle.size(); i++) begin
            checks++;
            if (wr_cycle[i] - wr_cycle[i-1] != 2) begin
                errors++; $display("FAIL b2b_spacing[%0d] got %0d want 2", i, wr_cycle[i] - wr_cycle[i-1]);
            end
        end
        checks++;
        if (grant_count0 - b0 != 16'd4 || grant_count1 - b1 != 16'd4) begin
            errors++; $display("FAIL b2b_counts got +%0d/+%0d want +4/+4", grant_count0 - b0, grant_count1 - b1);
        end
    endtask

    task automatic test_full();
        logic [15:0] b0 = grant_count0;
        logic [15:0] b1 = grant_count1;
        out_full = 1'b1;
        push_pair(0, 32'd100, 32'd23);
        push_pair(1, 32'd50, 32'd8);
        wait_grant("full");
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_wr_en !== 1'b0 || out_din !== 32'd123 || out_tag !== 1'b0 ||
                {c0_inA_rd_en, c0_inB_rd_en, c1_inA_rd_en, c1_inB_rd_en} !== 4'b0) begin
                errors++; $display("FAIL full_hold[%0d] got wr=%b din=%h tag=%b rd=%b%b%b%b want wr=0 din=7b tag=0 rd=0000",
                                   i, out_wr_en, out_din, out_tag, c0_inA_rd_en, c0_inB_rd_en, c1_inA_rd_en, c1_inB_rd_en);
            end
            tick();
        end
        out_full = 1'b0;
        wait_idle("full");
        checks++;
        if (grant_count0 - b0 != 16'd1 || grant_count1 - b1 != 16'd1) begin
            errors++; $display("FAIL full_counts got +%0d/+%0d want +1/+1", grant_count0 - b0, grant_count1 - b1);
        end
    endtask

    task automatic test_overflow();
        push_pair(0, 32'h7FFF_FFFF, 32'd1);
        push_pair(1, 32'h8000_0000, 32'd1);
        wait_idle("overflow");
        checks++;
        if (last_out0 !== 32'h8000_0000) begin errors++; $display("FAIL ovf_add got %h want 80000000", last_out0); end
        checks++;
        if (last_out1 !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_sub got %h want 7fffffff", last_out1); end
    endtask

    task automatic test_partial_and_reset();
        logic [DW-1:0] dropped;
        q_c0a.push_back(32'd9);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({c0_inA_rd_en, c0_inB_rd_en, c1_inA_rd_en, c1_inB_rd_en} !== 4'b0) begin
                errors++; $display("FAIL partial_rd_en[%0d] got %b%b%b%b want 0000",
                                   i, c0_inA_rd_en, c0_inB_rd_en, c1_inA_rd_en, c1_inB_rd_en);
            end
        end
        out_full = 1'b1;
        q_c0b.push_back(32'd4);
        exp_q0.push_back(32'd13);
        wait_grant("partial");
        reset = 1'b0;
        dropped = exp_q0.pop_back();
        push_pair(0, 32'd2, 32'd2);
        out_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_wr_en !== 1'b0 || out_din !== '0 || grant_count0 !== 16'd0 || grant_count1 !== 16'd0 ||
                c0_inA_rd_en !== 1'b0 || q_c0a.size() != 1) begin
                errors++; $display("FAIL midreset[%0d] got wr=%b din=%h cnt=%0d/%0d rd=%b depth=%0d want 0,0,0/0,0,1 (dropped %h)",
                                   i, out_wr_en, out_din, grant_count0, grant_count1, c0_inA_rd_en, q_c0a.size(), dropped);
            end
        end
        reset = 1'b1;
        wait_idle("after_reset");
        checks++;
        if (grant_count0 !== 16'd1 || grant_count1 !== 16'd0 || last_out0 !== 32'd4) begin
            errors++; $display("FAIL after_reset got cnt=%0d/%0d din=%h want 1/0 and 4", grant_count0, grant_count1, last_out0);
        end
    endtask

    initial begin
        test_reset();
        test_ch0_only();
        test_ch1_only();
        test_back_to_back();
        test_full();
        test_overflow();
        test_partial_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
